// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory access controller.
// Latency: n/a (types, constants and a pure request check).
// Backpressure: n/a.
package dm_pkg;

  localparam int DM_AW = 7;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    RESP
  } dm_state_e;

  // A request is rejected when it is misaligned for its size or uses the reserved size code.
  function automatic logic req_bad(input logic [1:0] size, input logic [DM_AW-1:0] addr);
    case (size)
      SZ_BYTE: req_bad = 1'b0;
      SZ_HALF: req_bad = addr[0];
      SZ_WORD: req_bad = (addr[1:0] != 2'b00);
      default: req_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_merge.sv
// Byte-lane logic: extends sub-word load data and merges sub-word store data into a read word.
// Latency: combinational.
// Backpressure: none.
module dm_lane_merge
  import dm_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic sext;
  assign sext = ~uns;

  always_comb begin
    load_data  = rdata;
    merge_data = wdata;
    case (size)
      SZ_BYTE: begin
        load_data  = {{24{sext & rdata[7]}}, rdata[7:0]};
        merge_data = {rdata[31:8], wdata[7:0]};
      end
      SZ_HALF: begin
        load_data  = {{16{sext & rdata[15]}}, rdata[15:0]};
        merge_data = {rdata[31:16], wdata[15:0]};
      end
      default: begin
        load_data  = rdata;
        merge_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// MEM-stage load/store controller driving a 4-byte little-endian data memory port.
// Latency: response 2 cycles after accept (load, word store), 3 (sub-word store), 1 (error).
// Backpressure: one request in flight; req_ready only in IDLE, responses cannot be stalled.
module dm_access_ctrl
  import dm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DM_AW-1:0]  req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DM_AW-1:0]  mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  dm_state_e        state;
  logic [1:0]       size_q;
  logic             uns_q;
  logic [DM_AW-1:0] addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      load_data;
  logic [31:0]      merge_data;
  logic             bad;

  assign bad = req_bad(req_size, req_addr);

  dm_lane_merge u_lane_merge (
    .size       (size_q),
    .uns        (uns_q),
    .wdata      (wdata_q),
    .rdata      (mem_rdata),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // Strobes come straight from the state register, so rd and wr are mutually exclusive.
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign mem_rd     = (state == LOAD) || (state == RMW_RD);
  assign mem_wr     = (state == WRITE);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      size_q     <= SZ_BYTE;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            size_q     <= req_size;
            uns_q      <= req_unsigned;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            resp_err   <= bad;
            resp_rdata <= '0;
            if (bad)                    state <= RESP;
            else if (!req_we)           state <= LOAD;
            else if (req_size == SZ_WORD) state <= WRITE;
            else                        state <= RMW_RD;
          end
        end
        LOAD: begin
          resp_rdata <= load_data;
          state      <= RESP;
        end
        // wdata_q is reused to hold the merged word so WRITE drives it unchanged.
        RMW_RD: begin
          wdata_q <= merge_data;
          state   <= WRITE;
        end
        WRITE: begin
          state <= RESP;
        end
        RESP: begin
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
